// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The optional per-requester beat counters are enabled with `define FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time widths; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // LSB of requester k's slice in a flattened data bus.
  function automatic int data_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first set request strictly
// after ptr, wrapping around. The request vector is doubled so the wrap is a
// plain masked lowest-bit search.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] hit;

  // Window (ptr, ptr+NUM_REQ] over the doubled vector, lowest hit wins.
  always_comb begin
    dbl    = {req, req};
    mask   = '0;
    gnt_id = '0;
    any    = |req;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      mask[i] = (i > int'(ptr)) && (i <= int'(ptr) + NUM_REQ);
    end
    hit = dbl & mask;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (hit[i]) gnt_id = ID_W'(i % NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing the async FIFO write port.
// A grant is held for a whole packet or MAX_BURST beats, whichever ends first.
// Optional feature: `define FIFO_ARB_STATS_EN adds o_beat_cnt, saturating
// per-requester accepted-beat counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int D_SIZE    = 16,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  input  logic [NUM_REQ*D_SIZE-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_wr_en,
  output logic [D_SIZE-1:0]         o_wr_data,
  input  logic                      i_full,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy
`ifdef FIFO_ARB_STATS_EN
  ,output logic [NUM_REQ*CNT_W-1:0] o_beat_cnt
`endif
);

  localparam int BC_W = clog2(MAX_BURST + 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gid;
  logic [BC_W-1:0] bcnt;
  logic [BC_W-1:0] bcnt_inc;
  logic [ID_W-1:0] arb_id;
  logic            arb_any;
  logic            beat;
  logic            rel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (i_req_valid),
    .ptr    (ptr),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign o_grant_id = gid;
  assign o_busy     = (state == ST_LOCK);
  assign bcnt_inc   = bcnt + 1'b1;

  // Zero-latency beat path: accept, ready, write enable and data mux.
  always_comb begin
    beat        = (state == ST_LOCK) && i_req_valid[gid] && !i_full;
    o_req_ready = '0;
    o_wr_en     = beat;
    o_wr_data   = '0;
    if (state == ST_LOCK) o_req_ready[gid] = !i_full;
    if (beat) o_wr_data = i_req_data[data_lsb(int'(gid), D_SIZE) +: D_SIZE];
    // Packet end and burst cap coinciding is still one release.
    rel = beat && (i_req_last[gid] || (bcnt_inc == BC_W'(MAX_BURST)));
  end

  // Next state: arbitrate for one cycle in IDLE, hold in LOCK until release.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_any) state_nxt = ST_LOCK;
      ST_LOCK: if (rel)     state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Grant capture, burst counting and round-robin pointer update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr  <= ID_W'(NUM_REQ - 1);
      gid  <= '0;
      bcnt <= '0;
    end else begin
      if (state == ST_IDLE && arb_any) begin
        gid  <= arb_id;
        bcnt <= '0;
      end
      if (beat) bcnt <= bcnt_inc;
      if (rel)  ptr  <= gid;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    logic [CNT_W-1:0] cnt;

    // Saturating count of beats accepted from requester k.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                         cnt <= '0;
      else if (beat && gid == ID_W'(k) && cnt != '1)     cnt <= cnt + 1'b1;
    end

    assign o_beat_cnt[k*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a per-cycle reference model of the
// arbitration rules pushes expected outputs; a negedge monitor compares.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MB  = 8;
  localparam int CW  = 4;
  localparam int IDW = 2;
  localparam int DEP = 2048;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid, last, ready;
  logic [N*DW-1:0] data;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            full;
  logic [IDW-1:0]  gid;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .D_SIZE(DW), .MAX_BURST(MB), .CNT_W(CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_last  (last),
    .i_req_data  (data),
    .o_req_ready (ready),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data),
    .i_full      (full),
    .o_grant_id  (gid),
    .o_busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,.o_beat_cnt (beat_cnt)
`endif
  );

  typedef struct packed {
    logic           wr;
    logic [DW-1:0]  d;
    logic [N-1:0]   rdy;
    logic           busy;
    logic [IDW-1:0] gid;
  } exp_t;

  exp_t exp_q[$];

  // Per-requester beat sources: {last, data}
  logic [DW:0] src [N][DEP];
  int hd[N], tl[N];
  int seq;

  // Reference model state
  bit m_lock;
  int m_g, m_cnt, m_ptr;
  int mstat[N];

  int n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int k, input int len);
    if (tl[k] + len > DEP) return;
    for (int b = 0; b < len; b++) begin
      src[k][tl[k]] = {(b == len-1), 2'(k), 14'(seq)};
      tl[k]++;
      seq++;
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (hd[k] < tl[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_g = 0; m_cnt = 0; m_ptr = N-1;
    for (int k = 0; k < N; k++) mstat[k] = 0;
  endtask

  // Drive one cycle (entered #1 after posedge), predict outputs, advance model.
  task automatic drive_cycle(input int vpct, input int fpct);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (hd[k] < tl[k] && $urandom_range(99) < vpct) begin
        valid[k] = 1'b1;
        {last[k], data[k*DW +: DW]} = src[k][hd[k]];
      end else begin
        valid[k] = 1'b0;
        last[k]  = 1'($urandom);
        data[k*DW +: DW] = 16'($urandom);
      end
    end
    full = ($urandom_range(99) < fpct);
    e = '0;
    e.busy = m_lock;
    e.gid  = IDW'(m_g);
    if (!m_lock) begin
      for (int j = 1; j <= N && !m_lock; j++) begin
        int idx;
        idx = (m_ptr + j) % N;
        if (valid[idx]) begin
          m_lock = 1; m_g = idx; m_cnt = 0;
        end
      end
    end else begin
      e.rdy[m_g] = !full;
      if (valid[m_g] && !full) begin
        e.wr = 1'b1;
        e.d  = data[m_g*DW +: DW];
        hd[m_g]++;
        m_cnt++;
        if (mstat[m_g] < (1 << CW) - 1) mstat[m_g]++;
        if (last[m_g] || m_cnt == MB) begin
          m_lock = 0; m_ptr = m_g;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((pending() || m_lock) && c < 600) begin
      drive_cycle(100, 0);
      c++;
    end
    for (int k = 0; k < N; k++) chk("drain_complete", 32'(hd[k]), 32'(tl[k]));
  endtask

  task automatic check_zero_outputs();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_beat_cnt", 32'(beat_cnt), 0);
`endif
  endtask

  // Reset asserted mid-clock with every valid high.
  task automatic mid_reset();
    @(negedge clk); #1;
    valid = '1;
    rst   = 1'b1;
    #1;
    check_zero_outputs();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: one expectation per driven cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_en", 32'(wr_en), 32'(e.wr));
      chk("wr_data", 32'(wr_data), 32'(e.d));
      chk("ready", 32'(ready), 32'(e.rdy));
      chk("busy", 32'(busy), 32'(e.busy));
      if (e.busy) chk("grant_id", 32'(gid), 32'(e.gid));
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; seq = 0;
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; end
    rst = 1'b1; valid = '0; last = '0; data = '0; full = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_zero_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single source: requester 2, three beats.
    push_pkt(2, 3);
    for (int i = 0; i < 8; i++) drive_cycle(100, 0);

    // Fairness: continuous 1-beat packets from all four.
    for (int r = 0; r < 4; r++) for (int k = 0; k < N; k++) push_pkt(k, 1);
    for (int i = 0; i < 34; i++) drive_cycle(100, 0);
    drain();

    // Burst cap: 12-beat packet on 1 while 2 waits.
    push_pkt(1, 12);
    push_pkt(2, 3);
    drain();

    // Backpressure mid-burst spanning the burst cap.
    push_pkt(0, 12);
    for (int i = 0; i < 3; i++) drive_cycle(100, 0);
    for (int i = 0; i < 3; i++) drive_cycle(100, 100);
    drain();

    // Reset with everyone requesting: requester 0 must win first.
    for (int k = 0; k < N; k++) push_pkt(k, 2);
    drive_cycle(100, 0);
    drive_cycle(100, 0);
    mid_reset();
    drain();

    // Randomised traffic with a mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        int k;
        k = $urandom_range(N-1);
        if (tl[k] - hd[k] < 24) push_pkt(k, $urandom_range(12, 1));
      end
      if (i == 700) mid_reset();
      drive_cycle(75, 20);
    end
    drain();

    // Stats: 20 beats from requester 3 after a clean reset.
    mid_reset();
    push_pkt(3, 8);
    push_pkt(3, 8);
    push_pkt(3, 4);
    drain();
    drive_cycle(0, 0);
`ifdef FIFO_ARB_STATS_EN
    for (int k = 0; k < N; k++)
      chk("beat_cnt", 32'(beat_cnt[k*CW +: CW]), 32'(mstat[k]));
    chk("beat_cnt3_sat", 32'(beat_cnt[3*CW +: CW]), 15);
`endif

    @(negedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
